// File: rtl/cacheline_adaptor.sv
// ============================================================================
// cacheline_adaptor : splits cache-line fills/writebacks into memory bursts
// Revision 1.0
// ============================================================================
`default_nettype none

module cacheline_adaptor #(
    parameter int S_LINE   = 256,
    parameter int S_BURST  = 64,
    parameter int N_BURST  = S_LINE / S_BURST,
    parameter int S_OFFSET = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [S_LINE-1:0]  line_i,
    output logic [S_LINE-1:0]  line_o,
    input  logic [31:0]        address_i,
    input  logic               read_i,
    input  logic               write_i,
    output logic               resp_o,
    input  logic [S_BURST-1:0] burst_i,
    output logic [S_BURST-1:0] burst_o,
    output logic [31:0]        address_o,
    output logic               read_o,
    output logic               write_o,
    input  logic               resp_i
);

    localparam int CNT_W = (N_BURST > 1) ? $clog2(N_BURST) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_BURST - 1);
    localparam logic [31:0] OFFSET_MASK = ~((32'd1 << S_OFFSET) - 32'd1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RD   = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]        state;
    logic [1:0]        state_next;
    logic [CNT_W-1:0]  cnt;
    logic [S_LINE-1:0] buffer;
    logic [31:0]       addr_reg;
    logic              last_beat;

    assign last_beat = resp_i && (cnt == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (write_i) begin
                    state_next = WR;
                end else if (read_i) begin
                    state_next = RD;
                end
            end
            RD:      if (last_beat) state_next = DONE;
            WR:      if (last_beat) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    // Full address is kept; offset bits are cleared only on the way out.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= '0;
            buffer   <= '0;
            addr_reg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (write_i) begin
                        buffer   <= line_i;
                        addr_reg <= address_i;
                        cnt      <= '0;
                    end else if (read_i) begin
                        addr_reg <= address_i;
                        cnt      <= '0;
                    end
                end
                RD: begin
                    if (resp_i) begin
                        buffer[int'(cnt)*S_BURST +: S_BURST] <= burst_i;
                        cnt <= cnt + 1'b1;
                    end
                end
                WR: begin
                    if (resp_i) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        read_o    = 1'b0;
        write_o   = 1'b0;
        resp_o    = 1'b0;
        burst_o   = '0;
        line_o    = buffer;
        address_o = addr_reg & OFFSET_MASK;
        case (state)
            RD: read_o = 1'b1;
            WR: begin
                write_o = 1'b1;
                burst_o = buffer[int'(cnt)*S_BURST +: S_BURST];
            end
            DONE:    resp_o = 1'b1;
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: doc/cacheline_adaptor.md
Name: cacheline_adaptor

Overview:
- Converts line-granular cache misses and writebacks into fixed-length bursts to physical memory.
- Sits directly downstream of the cache controller's pmem port (pmem_read / pmem_write / pmem_address / pmem_resp).
- Upstream: one full line moved per request. Downstream: N_BURST beats of S_BURST bits, lowest beat first.
- One request is outstanding at a time. The requester holds its request until `resp_o`.

Parameters:
- S_LINE, 256, cache line width in bits
- S_BURST, 64, memory beat width in bits
- N_BURST, S_LINE/S_BURST (4), beats per line; must be a power of two, ≥2
- S_OFFSET, 5, line-offset bits; forced to zero on `address_o`

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; synchronous, active-low (0 = reset)
- line_i  in  S_LINE  writeback line from cache
- line_o  out  S_LINE  fill line to cache
- address_i  in  32  line address from cache
- read_i  in  1  fill request
- write_i  in  1  writeback request
- resp_o  out  1  one-cycle completion pulse to cache
- burst_i  in  S_BURST  read beat from memory
- burst_o  out  S_BURST  write beat to memory
- address_o  out  32  burst base address, {addr[31:S_OFFSET], 0}
- read_o  out  1  memory read request
- write_o  out  1  memory write request
- resp_i  in  1  memory beat acknowledge, one beat per high cycle

Behaviour:
- Reset values (rst==0 at a clock edge):
  - state=IDLE, beat counter=0, line buffer=0, address register=0.
  - read_o=0, write_o=0, resp_o=0, burst_o=0, line_o=0, address_o=0.
- Reset mid-burst: abandon the transfer, return to IDLE next cycle, drop read_o/write_o. No resp_o is issued.
- States: IDLE, RD, WR, DONE.
- IDLE:
  - If write_i: capture line_i into the buffer and address_i into the address register; counter=0; go to WR.
  - Else if read_i: capture address_i; counter=0; go to RD.
  - write_i has priority if both are high.
- RD:
  - read_o=1.
  - Each cycle with resp_i=1: store burst_i into buffer slice [cnt*S_BURST +: S_BURST], then cnt++.
  - On the beat where cnt==N_BURST-1: go to DONE.
  - resp_i=0 cycles (gaps) are legal and hold state.
- WR:
  - write_o=1; burst_o = buffer slice [cnt].
  - Each cycle with resp_i=1 consumes that beat; cnt++.
  - On the last beat: go to DONE.
- DONE:
  - resp_o=1 for exactly one cycle; line_o = buffer (valid for reads).
  - read_o=write_o=0.
  - Next state is IDLE unconditionally. Requests present during DONE are ignored.
  - Latency: resp_o asserts the cycle after the final beat.
- read_o/write_o stay continuously high from the cycle after capture through the final beat. Both are never high together.
- address_o is driven from the address register during RD/WR/DONE. It stays stable for the whole transaction; changes on address_i after capture have no effect.
- line_o holds its value after DONE until the next read overwrites buffer slices.
- Beat counter is log2(N_BURST) bits and wraps to 0 on the final beat.
- resp_i while in IDLE or DONE is ignored: no state change, no buffer write.
- Minimum back-to-back spacing: IDLE → RD/WR → 4 beats → DONE → IDLE. A new request is accepted no earlier than the cycle after DONE.

Test Plan:
- Read, consecutive beats: address_i=0x1234_5678, read_i=1; memory returns beats 0x…A0, A1, A2, A3 on 4 consecutive resp_i cycles → address_o=0x1234_5660, read_o high 4 cycles, resp_o one cycle later, line_o={A3,A2,A1,A0}.
- Write, gapped acks: line_i = beats {D3,D2,D1,D0}, write_i=1; resp_i pattern 1,0,0,1,1,0,1 → burst_o shows D0, D1, D1, D1, D2, D3, D3 on those cycles (held across gaps); write_o drops after the 4th ack; single resp_o.
- Simultaneous read_i=write_i=1 in IDLE → WR taken; read_o never asserted; one resp_o.
- Input stability: change address_i and line_i mid-write → address_o and burst_o unaffected.
- Reset mid-operation: rst=0 after 2 read beats → next cycle read_o=0, resp_o=0, state IDLE; a fresh read after reset completes with correct data.
- Stray ack: resp_i=1 while IDLE and during DONE → no resp_o, line_o unchanged.
